// File: rtl/load_store_unit_if.sv
// Backend request/response and data_memory handshake bundle for load_store_unit.
// master = the LSU itself; slave = the surrounding backend plus data_memory.
interface load_store_unit_if #(
   parameter int TAG_WIDTH = 5
) ();
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_is_store;
   logic                 req_byte;
   logic [31:0]          req_addr;
   logic [31:0]          req_data;
   logic [TAG_WIDTH-1:0] req_tag;

   logic                 resp_valid;
   logic                 resp_ready;
   logic [TAG_WIDTH-1:0] resp_tag;
   logic [31:0]          resp_data;
   logic                 resp_is_store;
   logic                 resp_error;

   logic                 mem_write_enable;
   logic [31:0]          mem_write_address;
   logic [31:0]          mem_write_value;
   logic                 mem_store_byte;
   logic                 mem_read_enable;
   logic [31:0]          mem_read_address;
   logic                 mem_load_byte;
   logic [31:0]          mem_read_value;
   logic                 mem_write_valid;
   logic                 mem_read_valid;

   modport master (
      input  req_valid, req_is_store, req_byte, req_addr, req_data, req_tag,
      output req_ready,
      output resp_valid, resp_tag, resp_data, resp_is_store, resp_error,
      input  resp_ready,
      output mem_write_enable, mem_write_address, mem_write_value, mem_store_byte,
      output mem_read_enable, mem_read_address, mem_load_byte,
      input  mem_read_value, mem_write_valid, mem_read_valid
   );

   modport slave (
      output req_valid, req_is_store, req_byte, req_addr, req_data, req_tag,
      input  req_ready,
      input  resp_valid, resp_tag, resp_data, resp_is_store, resp_error,
      output resp_ready,
      input  mem_write_enable, mem_write_address, mem_write_value, mem_store_byte,
      input  mem_read_enable, mem_read_address, mem_load_byte,
      output mem_read_value, mem_write_valid, mem_read_valid
   );
endinterface

// File: rtl/load_store_unit.sv
// In-order load/store issue stage: request FIFO feeding a one-op-at-a-time FSM on data_memory.
// Optional LSU_TIMEOUT_EN adds a watchdog that errors out an access whose valid never arrives.
module load_store_unit #(
   parameter int QUEUE_DEPTH    = 4,
   parameter int TAG_WIDTH      = 5,
   parameter int MEM_SIZE_BYTES = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset,
   load_store_unit_if.master bus
);
   localparam int PW = $clog2(QUEUE_DEPTH);

   typedef struct packed {
      logic                 is_store;
      logic                 is_byte;
      logic [31:0]          addr;
      logic [31:0]          data;
      logic [TAG_WIDTH-1:0] tag;
   } req_t;

   typedef enum logic [2:0] {IDLE, WRITE_WAIT, READ_WAIT, GAP, RESP} state_t;

   req_t            fifo_q [QUEUE_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PW:0]     count_q;
   logic            push, pop, head_err, tmo_hit;
   req_t            head, req_in;

   state_t               state_q, state_d;
   logic                 we_q, we_d, re_q, re_d, mbyte_q, mbyte_d;
   logic [31:0]          maddr_q, maddr_d, mval_q, mval_d;
   logic [TAG_WIDTH-1:0] rtag_q, rtag_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 rstore_q, rstore_d, rerr_q, rerr_d;

   assign req_in        = '{bus.req_is_store, bus.req_byte, bus.req_addr, bus.req_data, bus.req_tag};
   assign bus.req_ready = (count_q != (PW+1)'(QUEUE_DEPTH));
   assign push          = bus.req_valid && bus.req_ready;
   assign pop           = (state_q == IDLE) && (count_q != '0);
   assign head          = fifo_q[rd_ptr_q];
   assign head_err      = (!head.is_byte && head.addr[1:0] != 2'b00) ||
                          (head.addr >= 32'(MEM_SIZE_BYTES));

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= req_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (PW+1)'(1);
            2'b01:   count_q <= count_q - (PW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      re_d     = re_q;
      mbyte_d  = mbyte_q;
      maddr_d  = maddr_q;
      mval_d   = mval_q;
      rtag_d   = rtag_q;
      rdata_d  = rdata_q;
      rstore_d = rstore_q;
      rerr_d   = rerr_q;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               rtag_d   = head.tag;
               rstore_d = head.is_store;
               rdata_d  = '0;
               rerr_d   = head_err;
               maddr_d  = head.addr;
               mval_d   = head.data;
               mbyte_d  = head.is_byte;
               if (head_err) begin
                  state_d = RESP;
               end else if (head.is_store) begin
                  we_d    = 1'b1;
                  state_d = WRITE_WAIT;
               end else begin
                  re_d    = 1'b1;
                  state_d = READ_WAIT;
               end
            end
         end
         WRITE_WAIT: begin
            if (bus.mem_write_valid) begin
               we_d    = 1'b0;
               state_d = GAP;
            end else if (tmo_hit) begin
               we_d    = 1'b0;
               rerr_d  = 1'b1;
               state_d = GAP;
            end
         end
         READ_WAIT: begin
            if (bus.mem_read_valid) begin
               rdata_d = bus.mem_read_value;
               re_d    = 1'b0;
               state_d = GAP;
            end else if (tmo_hit) begin
               rdata_d = '0;
               rerr_d  = 1'b1;
               re_d    = 1'b0;
               state_d = GAP;
            end
         end
         // Idle cycle so data_memory sees the enable low and restarts its latency count.
         GAP:     state_d = RESP;
         RESP:    if (bus.resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] tmo_q, tmo_d;

   always_comb begin
      tmo_d = '0;
      if (state_d == state_q && (state_q == WRITE_WAIT || state_q == READ_WAIT))
         tmo_d = tmo_q + TW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) tmo_q <= '0;
      else       tmo_q <= tmo_d;
   end

   assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         re_q     <= 1'b0;
         mbyte_q  <= 1'b0;
         maddr_q  <= '0;
         mval_q   <= '0;
         rtag_q   <= '0;
         rdata_q  <= '0;
         rstore_q <= 1'b0;
         rerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         re_q     <= re_d;
         mbyte_q  <= mbyte_d;
         maddr_q  <= maddr_d;
         mval_q   <= mval_d;
         rtag_q   <= rtag_d;
         rdata_q  <= rdata_d;
         rstore_q <= rstore_d;
         rerr_q   <= rerr_d;
      end
   end

   assign bus.mem_write_enable  = we_q;
   assign bus.mem_write_address = maddr_q;
   assign bus.mem_write_value   = mval_q;
   assign bus.mem_store_byte    = mbyte_q;
   assign bus.mem_read_enable   = re_q;
   assign bus.mem_read_address  = maddr_q;
   assign bus.mem_load_byte     = mbyte_q;

   assign bus.resp_valid    = (state_q == RESP);
   assign bus.resp_tag      = rtag_q;
   assign bus.resp_data     = rdata_q;
   assign bus.resp_is_store = rstore_q;
   assign bus.resp_error    = rerr_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: data_memory stand-in with variable latency, byte-array
// reference model with an in-order response queue, directed table plus random traffic.
module tb_load_store_unit;
   localparam int TW = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   load_store_unit_if #(.TAG_WIDTH(TW)) bus ();

   load_store_unit #(
      .QUEUE_DEPTH(4), .TAG_WIDTH(TW), .MEM_SIZE_BYTES(32), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct {
      bit            st;
      bit            bt;
      logic [31:0]   addr;
      logic [31:0]   data;
      logic [TW-1:0] tag;
      logic [31:0]   exp_data;
      bit            exp_err;
   } vec_t;

   typedef struct {
      logic [TW-1:0] tag;
      logic [31:0]   data;
      bit            st;
      bit            err;
   } rsp_t;

   int errors = 0;
   int checks = 0;

   // data_memory stand-in: valid pulses after `lat` cycles of a held enable
   logic [7:0] dmem [0:31] = '{default: 8'h00};
   int         lat  = 10;
   int         mcnt = 0;
   logic [4:0] wa, ra;
   assign wa = bus.mem_write_address[4:0];
   assign ra = bus.mem_read_address[4:0];

   always @(posedge clk) begin
      if (!(bus.mem_write_enable || bus.mem_read_enable) || bus.mem_write_valid || bus.mem_read_valid) begin
         mcnt                <= 0;
         bus.mem_write_valid <= 1'b0;
         bus.mem_read_valid  <= 1'b0;
      end else if (mcnt >= lat - 1) begin
         mcnt <= 0;
         if (bus.mem_write_enable) begin
            dmem[wa] <= bus.mem_write_value[7:0];
            if (!bus.mem_store_byte) begin
               dmem[wa + 5'd1] <= bus.mem_write_value[15:8];
               dmem[wa + 5'd2] <= bus.mem_write_value[23:16];
               dmem[wa + 5'd3] <= bus.mem_write_value[31:24];
            end
            bus.mem_write_valid <= 1'b1;
         end else begin
            if (bus.mem_load_byte) bus.mem_read_value <= {24'h0, dmem[ra]};
            else bus.mem_read_value <= {dmem[ra + 5'd3], dmem[ra + 5'd2], dmem[ra + 5'd1], dmem[ra]};
            bus.mem_read_valid <= 1'b1;
         end
      end else begin
         mcnt <= mcnt + 1;
      end
   end

   // Reference: program-order byte array and expected-response queue
   logic [7:0] ref_mem [0:31] = '{default: 8'h00};
   rsp_t       exp_q [$];

   task automatic model_accept(input bit st, input bit bt, input logic [31:0] a,
                               input logic [31:0] d, input logic [TW-1:0] t);
      rsp_t r;
      r.tag  = t;
      r.st   = st;
      r.data = 32'h0;
      r.err  = (!bt && a[1:0] != 2'b00) || (a >= 32);
      if (!r.err) begin
         if (st) begin
            if (bt) ref_mem[a] = d[7:0];
            else for (int k = 0; k < 4; k++) ref_mem[a + k] = d[8*k +: 8];
         end else begin
            if (bt) r.data = {24'h0, ref_mem[a]};
            else for (int k = 0; k < 4; k++) r.data[8*k +: 8] = ref_mem[a + k];
         end
      end
      exp_q.push_back(r);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic push(input bit st, input bit bt, input logic [31:0] a,
                       input logic [31:0] d, input logic [TW-1:0] t);
      int n = 0;
      bus.req_is_store = st;
      bus.req_byte     = bt;
      bus.req_addr     = a;
      bus.req_data     = d;
      bus.req_tag      = t;
      bus.req_valid    = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.req_ready) break;
         n++;
         if (n > 500) begin
            fail("push_accept");
            break;
         end
         @(posedge clk);
         #1 bus.resp_ready = 1'b1;
      end
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      if (n <= 500) model_accept(st, bt, a, d, t);
   endtask

   task automatic wait_resp(output bit ok);
      int n = 0;
      ok = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.resp_valid) begin
            ok = 1'b1;
            break;
         end
         n++;
         if (n > 400) begin
            fail("resp_wait");
            break;
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      bus.resp_ready = 1'b1;
      while (exp_q.size() != 0) begin
         @(posedge clk);
         n++;
         if (n > 3000) begin
            fail("drain");
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   bit   prev_en = 1'b0;
   bit   mon_en;
   int   low_cnt = 100;
   int   rises = 0;
   bit   last_ld_byte = 1'b0;
   rsp_t mon_r;
   vec_t tbl [14];

   initial begin
      bit          ok;
      int          r0, n;
      bit          st, bt;
      logic [31:0] a;

      bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_byte = 1'b0;
      bus.req_addr = '0; bus.req_data = '0; bus.req_tag = '0; bus.resp_ready = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (reset) begin
               prev_en = 1'b0;
               low_cnt = 100;
            end else begin
               mon_en = bus.mem_write_enable | bus.mem_read_enable;
               if (mon_en) chk("single_enable", 32'(bus.mem_write_enable & bus.mem_read_enable), 0);
               if (mon_en && !prev_en) begin
                  rises++;
                  chk("gap_before_access", 32'(low_cnt >= 1), 1);
                  if (bus.mem_read_enable) last_ld_byte = bus.mem_load_byte;
               end
               low_cnt = mon_en ? 0 : low_cnt + 1;
               prev_en = mon_en;
               if (bus.resp_valid && bus.resp_ready) begin
                  if (exp_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL unexpected_resp: tag %0d with nothing outstanding", bus.resp_tag);
                  end else begin
                     mon_r = exp_q.pop_front();
                     chk("model_tag",   32'(bus.resp_tag),      32'(mon_r.tag));
                     chk("model_data",  bus.resp_data,          mon_r.data);
                     chk("model_store", 32'(bus.resp_is_store), 32'(mon_r.st));
                     chk("model_error", 32'(bus.resp_error),    32'(mon_r.err));
                  end
               end
            end
         end
      join_none

      #2;
      chk("rst_req_ready",  32'(bus.req_ready), 1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 0);
      chk("rst_mem_we",     32'(bus.mem_write_enable), 0);
      chk("rst_mem_re",     32'(bus.mem_read_enable), 0);
      chk("rst_resp_data",  bus.resp_data, 0);
      chk("rst_resp_tag",   32'(bus.resp_tag), 0);
      chk("rst_resp_flags", 32'({bus.resp_error, bus.resp_is_store}), 0);
      chk("rst_mem_addr",   bus.mem_write_address | bus.mem_read_address | bus.mem_write_value, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;

      //            st    bt    addr          data          tag    exp_data      err
      tbl[0]  = '{1'b1, 1'b0, 32'h10,       32'hDEADBEEF, 5'd3,  32'h0,        1'b0};
      tbl[1]  = '{1'b0, 1'b0, 32'h10,       32'h0,        5'd4,  32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 32'h12,       32'h0,        5'd5,  32'h000000AD, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 32'h11,       32'h0,        5'd6,  32'h0,        1'b1};
      tbl[4]  = '{1'b0, 1'b0, 32'h40,       32'h0,        5'd7,  32'h0,        1'b1};
      tbl[5]  = '{1'b1, 1'b1, 32'h13,       32'h000055AA, 5'd8,  32'h0,        1'b0};
      tbl[6]  = '{1'b0, 1'b0, 32'h10,       32'h0,        5'd9,  32'hAAADBEEF, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 32'h1F,       32'h0,        5'd10, 32'h0,        1'b0};
      tbl[8]  = '{1'b0, 1'b1, 32'h20,       32'h0,        5'd11, 32'h0,        1'b1};
      tbl[9]  = '{1'b0, 1'b0, 32'h1C,       32'h0,        5'd12, 32'h0,        1'b0};
      tbl[10] = '{1'b1, 1'b0, 32'h1E,       32'h11111111, 5'd13, 32'h0,        1'b1};
      tbl[11] = '{1'b1, 1'b0, 32'h1C,       32'h12345678, 5'd14, 32'h0,        1'b0};
      tbl[12] = '{1'b0, 1'b1, 32'h1D,       32'h0,        5'd15, 32'h00000056, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        5'd16, 32'h0,        1'b1};

      bus.resp_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         r0 = rises;
         push(tbl[i].st, tbl[i].bt, tbl[i].addr, tbl[i].data, tbl[i].tag);
         wait_resp(ok);
         if (ok) begin
            chk($sformatf("tbl%0d_tag", i),   32'(bus.resp_tag),      32'(tbl[i].tag));
            chk($sformatf("tbl%0d_data", i),  bus.resp_data,          tbl[i].exp_data);
            chk($sformatf("tbl%0d_store", i), 32'(bus.resp_is_store), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_error", i), 32'(bus.resp_error),    32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_mem_accesses", i), 32'(rises - r0), tbl[i].exp_err ? 0 : 1);
            if (!tbl[i].st && !tbl[i].exp_err)
               chk($sformatf("tbl%0d_load_byte", i), 32'(last_ld_byte), 32'(tbl[i].bt));
         end
         @(posedge clk); #1;
      end

      // Backpressure: one op parked in RESP, then the 4-entry FIFO fills
      bus.resp_ready = 1'b0;
      push(1'b0, 1'b0, 32'h10, 32'h0, 5'd20);
      wait_resp(ok);
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) push(1'b0, 1'b1, 32'h10 + k, 32'h0, TW'(21 + k));
      @(negedge clk);
      chk("bp_full_req_ready", 32'(bus.req_ready), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_stall_valid", 32'(bus.resp_valid), 1);
      chk("bp_stall_tag",   32'(bus.resp_tag), 20);
      chk("bp_still_full",  32'(bus.req_ready), 0);
      bus.resp_ready = 1'b1;
      push(1'b1, 1'b0, 32'h18, 32'hCAFEF00D, 5'd25);
      drain();

      // Reset while a load is waiting on data_memory
      lat = 20;
      push(1'b0, 1'b0, 32'h1C, 32'h0, 5'd30);
      n = 0;
      while (!bus.mem_read_enable && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.mem_read_enable) fail("reach_read_wait");
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      exp_q.delete();
      #1;
      chk("rst_mid_re",         32'(bus.mem_read_enable), 0);
      chk("rst_mid_we",         32'(bus.mem_write_enable), 0);
      chk("rst_mid_resp_valid", 32'(bus.resp_valid), 0);
      chk("rst_mid_req_ready",  32'(bus.req_ready), 1);
      @(posedge clk); #1 reset = 1'b0;
      lat = 10;
      push(1'b0, 1'b0, 32'h10, 32'h0, 5'd31);
      drain();

      // Random traffic against the reference model
      for (int i = 0; i < 60; i++) begin
         bus.resp_ready = ($urandom_range(0, 3) != 0);
         lat = $urandom_range(1, 6);
         st  = $urandom_range(0, 1) == 1;
         bt  = $urandom_range(0, 2) == 0;
         if (bt) a = 32'($urandom_range(0, 35));
         else a = 32'($urandom_range(0, 9) * 4 + (($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0));
         push(st, bt, a, $urandom(), TW'(i));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
